icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC in, INSTRUCTION out) and the block-wide instruction memory.
- Hits return the instruction in the same cycle.
- Misses stall the CPU via BUSYWAIT, fetch a 128-bit block from memory, fill the line, then serve the hit.
- Replaces the hand-coded PC→instruction lookup that currently feeds the cpu.

Parameters:
- ADDR_W, 10: number of PC byte-address bits used; higher PC bits are ignored.
- NUM_BLOCKS, 8: number of cache lines; power of two.
- BLOCK_WORDS, 4: 32-bit words per line; fixed at 4 to match the 128-bit memory data path.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- PC  in  32  fetch byte address from the cpu.
- INSTRUCTION  out  32  instruction word for PC; valid when BUSYWAIT=0.
- BUSYWAIT  out  1  stall to the cpu; high on a miss until the fill completes.
- MEM_ADDRESS  out  ADDR_W-4  block address to instruction memory, equal to PC[ADDR_W-1:4] of the missing access.
- MEM_READ  out  1  read request to instruction memory.
- MEM_READDATA  in  128  returned block; word0 is in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; the read completes on the first sampled edge with MEM_READ=1 and MEM_BUSYWAIT=0.

Behaviour:
- Address split:
  - offset = PC[3:2]; PC[1:0] ignored.
  - index = PC[4+IW-1:4], where IW = log2(NUM_BLOCKS).
  - tag = PC[ADDR_W-1:4+IW]; default is 3 bits.
- Per line: valid bit, tag, 128-bit data. No dirty bit, because the cache is read-only.
- hit = valid[index] && tag match. This is combinational from PC.
- INSTRUCTION = the selected word of data[index]. It is driven regardless of hit; the cpu qualifies it with BUSYWAIT.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: BUSYWAIT = !hit. On a miss, next state is MEM_READ and the miss block address is latched into a register driving MEM_ADDRESS.
  - MEM_READ: MEM_READ=1, BUSYWAIT=1, MEM_ADDRESS holds the latched value. Stay while MEM_BUSYWAIT=1. On an edge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
  - UPDATE: BUSYWAIT=1, MEM_READ=0. Write data, tag and valid into the latched index. Next state is IDLE.
  - Back in IDLE with an unchanged PC: hit, BUSYWAIT falls the same cycle.
- Miss penalty: 1 cycle (IDLE detect) + N memory-busy cycles + 1 (capture edge) + 1 (UPDATE), counted in rising edges from first miss detection to BUSYWAIT low.
- Reset (asserted low, any time, including mid-miss):
  - all valid bits cleared; FSM to IDLE.
  - MEM_READ=0 and MEM_ADDRESS=0 immediately.
  - BUSYWAIT follows !hit, so it is 1 after reset.
  - INSTRUCTION is undefined until the first fill; data arrays are not reset.
  - A memory read interrupted by reset is abandoned; no line is written.
- PC change during MEM_READ/UPDATE: ignored. The fill completes to the latched index/tag, then the new PC is evaluated in IDLE.
- Conflict miss (same index, different tag): the line is overwritten with no writeback.
- MEM_BUSYWAIT=0 on the first MEM_READ edge: legal, giving the minimum penalty of 3 edges.
- Unknown or X on PC in IDLE: treated as a miss only if hit evaluates to 0. The bench must not drive X.

Optional Feature:
- ICACHE_STATS_EN:
  - When defined, adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - HIT_COUNT increments on each rising edge in IDLE with hit=1 and PC different from the previous sampled PC (one count per fetch).
  - MISS_COUNT increments on each IDLE→MEM_READ transition.
  - Both clear on reset and saturate at all-ones.
- When undefined, neither port nor counter exists.

Decomposition:
- Shared package icache_pkg:
  - FSM state encoding (IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2).
  - Derived widths: IW, TAG_W, BLOCK_ADDR_W.
  - Constant BLOCK_BITS=128.
- Sub-module icache_ctrl: holds the FSM and miss-address latch, taking hit and MEM_BUSYWAIT and producing BUSYWAIT, MEM_READ and fill_en. Tag/data arrays and word select stay in icache_direct.

Test Plan:
- Reset low for 6 time units, then PC=0x000 → BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=0. With MEM_BUSYWAIT held 1 for 4 cycles, BUSYWAIT falls after 7 edges total and INSTRUCTION equals bits [31:0] of the returned block.
- PC=0x004, 0x008, 0x00C after that fill → BUSYWAIT=0 each cycle, MEM_READ never asserted, INSTRUCTION is words 1, 2, 3 of the block.
- PC=0x080 (index 0, tag 1) after the first fill → miss with MEM_ADDRESS=0x08. Then PC=0x000 → miss again (conflict), MEM_ADDRESS=0x00.
- PC=0x010 miss, and PC changes to 0x020 during MEM_READ → line 1 filled with the 0x010 block, then a new miss for 0x020 with MEM_ADDRESS=0x02. A later fetch of 0x010 hits.
- Reset asserted in the MEM_READ state → MEM_READ=0 the same time step. After release, PC=0x010 misses again (line not written).
- ICACHE_STATS_EN defined, sequence 0x000, 0x004, 0x008, 0x080 → MISS_COUNT=2, HIT_COUNT=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// derived field widths and the fill controller state encoding.
package icache_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int NUM_BLOCKS_DEF  = 8;
    localparam int BLOCK_WORDS_DEF = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_BITS      = 128;

    localparam int IW           = $clog2(NUM_BLOCKS_DEF);
    localparam int BLOCK_ADDR_W = ADDR_W_DEF - 4;
    localparam int TAG_W        = BLOCK_ADDR_W - IW;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/icache_ctrl.sv
// Miss handling FSM for icache_direct: latches the missing block address,
// runs the memory read handshake and pulses fill_en for the line write.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int AW = BLOCK_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hit,
    input  logic [AW-1:0] miss_addr,
    input  logic          mem_busywait,
    output logic          busywait,
    output logic          mem_read,
    output logic [AW-1:0] mem_address,
    output logic          capture_en,
    output logic          fill_en,
    output state_t        state
);

    // Memory handshake: a read request (mem_read=1) completes on the first
    // rising edge where mem_busywait is sampled low; data is taken that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            fill_en     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!hit) begin
                        state       <= ST_MEM_READ;
                        mem_read    <= 1'b1;
                        mem_address <= miss_addr;
                    end
                end
                ST_MEM_READ: begin
                    if (!mem_busywait) begin
                        state    <= ST_UPDATE;
                        mem_read <= 1'b0;
                        fill_en  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state   <= ST_IDLE;
                    fill_en <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    mem_read <= 1'b0;
                    fill_en  <= 1'b0;
                end
            endcase
        end
    end

    // In IDLE the stall tracks the lookup so a hit is served in the same cycle.
    assign busywait   = (state == ST_IDLE) ? !hit : 1'b1;
    assign capture_en = (state == ST_MEM_READ) && !mem_busywait;

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache; holds tag/data arrays and word select.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct
    import icache_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_BLOCKS  = NUM_BLOCKS_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic [ADDR_W-5:0]     MEM_ADDRESS,
    output logic                  MEM_READ,
    input  logic [BLOCK_BITS-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           HIT_COUNT,
    output logic [31:0]           MISS_COUNT
`endif
);

    localparam int LIW    = $clog2(NUM_BLOCKS);
    localparam int BLK_W  = ADDR_W - 4;
    localparam int LTAG_W = BLK_W - LIW;
    localparam int OFF_W  = $clog2(BLOCK_WORDS);

    logic [NUM_BLOCKS-1:0] valid;
    logic [LTAG_W-1:0]     tags [NUM_BLOCKS];
    logic [WORD_W-1:0]     data [NUM_BLOCKS][BLOCK_WORDS];
    logic [BLOCK_BITS-1:0] fill_data;

    logic [LIW-1:0]    idx;
    logic [LTAG_W-1:0] tag;
    logic [OFF_W-1:0]  off;
    logic              hit;
    logic              capture_en;
    logic              fill_en;
    state_t            ctrl_state;
    logic              unused_bits;

    assign off = PC[2 +: OFF_W];
    assign idx = PC[4 +: LIW];
    assign tag = PC[ADDR_W-1:4+LIW];

    assign hit         = valid[idx] && (tags[idx] == tag);
    assign INSTRUCTION = data[idx][off];
    assign unused_bits = ^{PC[31:ADDR_W], PC[1:0], ctrl_state};

    icache_ctrl #(.AW(BLK_W)) u_ctrl (
        .clk          (CLK),
        .rst_n        (RESET),
        .hit          (hit),
        .miss_addr    (PC[ADDR_W-1:4]),
        .mem_busywait (MEM_BUSYWAIT),
        .busywait     (BUSYWAIT),
        .mem_read     (MEM_READ),
        .mem_address  (MEM_ADDRESS),
        .capture_en   (capture_en),
        .fill_en      (fill_en),
        .state        (ctrl_state)
    );

    // The latched block address selects the line, so PC moves during a fill are harmless.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[MEM_ADDRESS[LIW-1:0]] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (capture_en) begin
            fill_data <= MEM_READDATA;
        end
        if (fill_en) begin
            tags[MEM_ADDRESS[LIW-1:0]] <= MEM_ADDRESS[BLK_W-1:LIW];
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                data[MEM_ADDRESS[LIW-1:0]][w] <= fill_data[w*WORD_W +: WORD_W];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] prev_pc;

    // A hit is counted once per distinct fetch address, not once per stalled cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
            prev_pc    <= '0;
        end else begin
            prev_pc <= PC;
            if (ctrl_state == ST_IDLE) begin
                if (hit && (PC != prev_pc) && (HIT_COUNT != 32'hFFFF_FFFF)) begin
                    HIT_COUNT <= HIT_COUNT + 32'd1;
                end
                if (!hit && (MISS_COUNT != 32'hFFFF_FFFF)) begin
                    MISS_COUNT <= MISS_COUNT + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct with a latency-programmable instruction memory model.
// Define ICACHE_STATS_EN for both the bench and the design to cover the counters.
module tb_icache_direct;

    logic         CLK;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic [5:0]   MEM_ADDRESS;
    logic         MEM_READ;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    int checks = 0;
    int passes = 0;
    int mem_lat = 4;
    int busy_cnt = 0;

    icache_direct dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READ     (MEM_READ),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] blk_word(input logic [5:0] a, input logic [1:0] w);
        return {16'hC0DE, 2'b00, a, 6'b000000, w};
    endfunction

    // Memory model: holds MEM_BUSYWAIT high for mem_lat cycles of each request.
    initial begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (MEM_READ) begin
                MEM_READDATA = {blk_word(MEM_ADDRESS, 2'd3), blk_word(MEM_ADDRESS, 2'd2),
                                blk_word(MEM_ADDRESS, 2'd1), blk_word(MEM_ADDRESS, 2'd0)};
                if (busy_cnt < mem_lat) begin
                    MEM_BUSYWAIT = 1'b1;
                    busy_cnt++;
                end else begin
                    MEM_BUSYWAIT = 1'b0;
                end
            end else begin
                MEM_BUSYWAIT = 1'b1;
                busy_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        #1;
        step();
        RESET = 1'b1;
        #1;
    endtask

    // Drives one fetch; exp_edges=0 means a same-cycle hit, otherwise the miss penalty.
    task automatic fetch(input logic [31:0] pc, input int exp_edges, input string name);
        int edges;
        logic [31:0] exp_instr;
        exp_instr = blk_word(pc[9:4], pc[3:2]);
        PC = pc;
        #1;
        if (exp_edges == 0) begin
            checks++;
            if (BUSYWAIT !== 1'b0) $display("FAIL %s hit_busywait: got %b want 0", name, BUSYWAIT);
            else passes++;
            checks++;
            if (INSTRUCTION !== exp_instr) $display("FAIL %s hit_instr: got %h want %h", name, INSTRUCTION, exp_instr);
            else passes++;
            step();
            checks++;
            if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0)
                $display("FAIL %s hit_quiet: got mem_read=%b busywait=%b want 0 0", name, MEM_READ, BUSYWAIT);
            else passes++;
        end else begin
            checks++;
            if (BUSYWAIT !== 1'b1) $display("FAIL %s miss_busywait: got %b want 1", name, BUSYWAIT);
            else passes++;
            edges = 0;
            while (BUSYWAIT !== 1'b0 && edges < 40) begin
                step();
                edges++;
                if (edges == 1) begin
                    checks++;
                    if (MEM_READ !== 1'b1 || MEM_ADDRESS !== pc[9:4])
                        $display("FAIL %s miss_req: got mem_read=%b addr=%h want 1 %h", name, MEM_READ, MEM_ADDRESS, pc[9:4]);
                    else passes++;
                end
            end
            checks++;
            if (edges != exp_edges) $display("FAIL %s miss_penalty: got %0d edges want %0d", name, edges, exp_edges);
            else passes++;
            checks++;
            if (INSTRUCTION !== exp_instr) $display("FAIL %s miss_instr: got %h want %h", name, INSTRUCTION, exp_instr);
            else passes++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h00)
            $display("FAIL reset_state: got busywait=%b mem_read=%b addr=%h want 1 0 00", BUSYWAIT, MEM_READ, MEM_ADDRESS);
        else passes++;
    endtask

    task automatic test_first_fill();
        mem_lat = 4;
        fetch(32'h000, 7, "first_fill");
    endtask

    task automatic test_hits();
        fetch(32'h004, 0, "hit_w1");
        fetch(32'h008, 0, "hit_w2");
        fetch(32'h00C, 0, "hit_w3");
    endtask

    task automatic test_conflict();
        mem_lat = 1;
        fetch(32'h080, 4, "conflict_a");
        fetch(32'h000, 4, "conflict_b");
        fetch(32'h00C, 0, "conflict_hit");
    endtask

    task automatic test_pc_change();
        int edges;
        mem_lat = 2;
        PC = 32'h010;
        #1;
        step();
        PC = 32'h020;
        edges = 1;
        while (BUSYWAIT !== 1'b0 && edges < 40) begin
            step();
            edges++;
            if (edges == 2) begin
                checks++;
                if (MEM_ADDRESS !== 6'h01) $display("FAIL pc_change_latched: got %h want 01", MEM_ADDRESS);
                else passes++;
            end
            if (edges == 5) begin
                checks++;
                if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b1)
                    $display("FAIL pc_change_idle: got mem_read=%b busywait=%b want 0 1", MEM_READ, BUSYWAIT);
                else passes++;
            end
            if (edges == 6) begin
                checks++;
                if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h02)
                    $display("FAIL pc_change_second: got mem_read=%b addr=%h want 1 02", MEM_READ, MEM_ADDRESS);
                else passes++;
            end
        end
        checks++;
        if (edges != 10) $display("FAIL pc_change_penalty: got %0d edges want 10", edges);
        else passes++;
        checks++;
        if (INSTRUCTION !== blk_word(6'h02, 2'd0))
            $display("FAIL pc_change_instr: got %h want %h", INSTRUCTION, blk_word(6'h02, 2'd0));
        else passes++;
        fetch(32'h010, 0, "pc_change_hit");
    endtask

    task automatic test_reset_mid_read();
        mem_lat = 5;
        PC = 32'h050;
        #1;
        step();
        step();
        checks++;
        if (MEM_READ !== 1'b1) $display("FAIL midrd_pre: got mem_read=%b want 1", MEM_READ);
        else passes++;
        RESET = 1'b0;
        #1;
        checks++;
        if (MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h00 || BUSYWAIT !== 1'b1)
            $display("FAIL midrd_reset: got mem_read=%b addr=%h busywait=%b want 0 00 1", MEM_READ, MEM_ADDRESS, BUSYWAIT);
        else passes++;
        step();
        RESET = 1'b1;
        #1;
        mem_lat = 0;
        fetch(32'h010, 3, "midrd_valid_cleared");
        fetch(32'h050, 3, "midrd_refetch");
    endtask

    task automatic test_min_penalty();
        mem_lat = 0;
        fetch(32'h040, 3, "min_penalty");
        fetch(32'h044, 0, "min_penalty_hit");
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        mem_lat = 1;
        PC = 32'h000;
        apply_reset();
        checks++;
        if (HIT_COUNT !== 32'd0 || MISS_COUNT !== 32'd0)
            $display("FAIL stats_reset: got hit=%0d miss=%0d want 0 0", HIT_COUNT, MISS_COUNT);
        else passes++;
        fetch(32'h000, 4, "stats_0");
        fetch(32'h004, 0, "stats_4");
        fetch(32'h008, 0, "stats_8");
        fetch(32'h080, 4, "stats_80");
        checks++;
        if (HIT_COUNT !== 32'd2 || MISS_COUNT !== 32'd2)
            $display("FAIL stats_counts: got hit=%0d miss=%0d want 2 2", HIT_COUNT, MISS_COUNT);
        else passes++;
    endtask
`endif

    initial begin
        RESET = 1'b0;
        PC = 32'h000;
        #6;
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        test_reset();
        test_first_fill();
        test_hits();
        test_conflict();
        test_pc_change();
        test_reset_mid_read();
        test_min_penalty();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
